// File: rtl/hlsm_job_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// hlsm_job_sequencer_pkg
//   Shared types and widths for the HLSM job sequencer and its result FIFO.
//   - Operand / result widths of the HLSM datapath core.
//   - 2-bit sequencer state type with its three state constants.
//   - Result FIFO entry {err, z, x}.
// ---------------------------------------------------------------------------
package hlsm_job_sequencer_pkg;

  localparam int OPND_W = 16;
  localparam int Z_W    = 8;
  localparam int X_W    = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_LAUNCH = 2'd1;
  localparam state_t S_WAIT   = 2'd2;

  typedef struct packed {
    logic           err;
    logic [Z_W-1:0] z;
    logic [X_W-1:0] x;
  } result_t;

endpackage

// File: rtl/hlsm_result_fifo.sv
// ---------------------------------------------------------------------------
// hlsm_result_fifo
//   First-word-fall-through FIFO of result entries. The head entry is visible
//   on pop_data whenever empty is low; a push into an empty FIFO becomes
//   visible one cycle later (no combinational bypass).
// Parameters
//   DEPTH      number of entries, power of 2, >= 2
// Ports
//   Clk        clock
//   Rst        synchronous active-high reset
//   push       write push_data (ignored when full unless popping too)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   full       all DEPTH entries occupied
//   empty      no entries; pop_data reads as zero
//   pop_data   head entry
// ---------------------------------------------------------------------------
module hlsm_result_fifo
  import hlsm_job_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    Clk,
  input  logic    Rst,
  input  logic    push,
  input  result_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output result_t pop_data
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  result_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push in the cycle its head is popped.
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers take non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale contents are never observed
  // because the read port is forced to zero while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/hlsm_job_sequencer.sv
// ---------------------------------------------------------------------------
// hlsm_job_sequencer
//   Front end for the HLSM datapath core. Accepts (a, b, c) jobs on a
//   valid/ready stream, launches the core with a one-cycle Start pulse,
//   waits for a rising edge on Done and queues {z, x} into a FWFT result
//   FIFO that drives a downstream valid/ready stream. One job in flight.
// Build option
//   HLSM_SEQ_WATCHDOG_EN  when defined, a WAIT-state watchdog aborts a job
//                         after TIMEOUT_CYCLES and queues {err=1, z=0, x=0};
//                         when undefined, WAIT lasts until Done and out_err
//                         is always 0.
// Parameters
//   DEPTH           result FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  watchdog limit (only with HLSM_SEQ_WATCHDOG_EN)
// Ports
//   Clk, Rst               clock, synchronous active-high reset
//   in_valid/in_ready      job handshake, in_a/in_b/in_c operands
//   hl_start               one-cycle Start pulse to the core
//   hl_a/hl_b/hl_c         registered operands, held until the next job
//   hl_done, hl_z, hl_x    core Done and results
//   out_valid/out_ready    result handshake, out_z/out_x/out_err payload
//   job_count              completed jobs including aborts (wrapping)
// ---------------------------------------------------------------------------
module hlsm_job_sequencer
  import hlsm_job_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef HLSM_SEQ_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  input  logic [OPND_W-1:0] in_c,
  output logic              hl_start,
  output logic [OPND_W-1:0] hl_a,
  output logic [OPND_W-1:0] hl_b,
  output logic [OPND_W-1:0] hl_c,
  input  logic              hl_done,
  input  logic [Z_W-1:0]    hl_z,
  input  logic [X_W-1:0]    hl_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Z_W-1:0]    out_z,
  output logic [X_W-1:0]    out_x,
  output logic              out_err,
  output logic [15:0]       job_count
);

  state_t            state_q, state_d;
  logic              start_q;
  logic [OPND_W-1:0] a_q, b_q, c_q;
  logic              done_q;
  logic [15:0]       job_count_q;
  logic              accept;
  logic              done_edge;
  logic              timeout;
  logic              push;
  result_t           push_data;
  result_t           pop_data;
  logic              fifo_full;
  logic              fifo_empty;

  assign in_ready  = !Rst && (state_q == S_IDLE) && !fifo_full;
  assign accept    = in_valid && in_ready;
  // Only a fresh 0->1 transition completes a job; a Done level left high by
  // the previous job is ignored.
  assign done_edge = hl_done && !done_q;

`ifdef HLSM_SEQ_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wd_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_LAUNCH) begin
      wd_cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end

  assign timeout = (state_q == S_WAIT) && (wd_cnt_q == WD_LIMIT);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // A Done edge coinciding with the timeout is a normal completion.
        if (done_edge) begin
          push      = 1'b1;
          push_data = '{err: 1'b0, z: hl_z, x: hl_x};
          state_d   = S_IDLE;
        end else if (timeout) begin
          push      = 1'b1;
          push_data = '{err: 1'b1, z: '0, x: '0};
          state_d   = S_IDLE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      done_q      <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= accept;
      done_q  <= hl_done;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
        c_q <= in_c;
      end
      if (push) job_count_q <= job_count_q + 16'd1;
    end
  end

  // Launch is gated on FIFO room and the FIFO can only drain afterwards, so
  // the completion push always finds a free slot.
  hlsm_result_fifo #(.DEPTH(DEPTH)) u_result_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pop_data  (pop_data)
  );

  assign hl_start  = start_q;
  assign hl_a      = a_q;
  assign hl_b      = b_q;
  assign hl_c      = c_q;
  assign out_valid = !fifo_empty;
  assign out_z     = pop_data.z;
  assign out_x     = pop_data.x;
  assign out_err   = pop_data.err;
  assign job_count = job_count_q;

endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hlsm_job_sequencer
//   Self-checking bench for hlsm_job_sequencer (DEPTH=2). A behavioural core
//   model answers Start with z = a + c, x = 2*b after a programmable latency.
//   Expected results are queued at job acceptance and compared in order as
//   the downstream side pops them; scenario tasks add timing checks.
//   Build with +define+HLSM_SEQ_WATCHDOG_EN to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_hlsm_job_sequencer;

  logic        Clk, Rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b, in_c;
  logic        hl_start;
  logic [15:0] hl_a, hl_b, hl_c;
  logic        hl_done;
  logic [7:0]  hl_z;
  logic [15:0] hl_x;
  logic        out_valid, out_ready;
  logic [7:0]  out_z;
  logic [15:0] out_x;
  logic        out_err;
  logic [15:0] job_count;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  // Core model controls
  int core_lat    = 6;
  bit core_sticky = 0;
  bit core_hang   = 0;
  bit rand_ready  = 0;

  typedef struct packed {
    logic        err;
    logic [7:0]  z;
    logic [15:0] x;
  } exp_t;

  exp_t exp_q[$];
  int   exp_jobs = 0;
  exp_t mon_e;

  hlsm_job_sequencer #(
    .DEPTH(2)
`ifdef HLSM_SEQ_WATCHDOG_EN
    , .TIMEOUT_CYCLES(10)
`endif
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .hl_start  (hl_start),
    .hl_a      (hl_a),
    .hl_b      (hl_b),
    .hl_c      (hl_c),
    .hl_done   (hl_done),
    .hl_z      (hl_z),
    .hl_x      (hl_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_x     (out_x),
    .out_err   (out_err),
    .job_count (job_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural HLSM core: latches operands on Start, raises Done after
  // core_lat cycles. Normally Done is cleared by Start; in sticky mode it is
  // not, and is only dropped for one cycle just before the new result.
  initial begin : core_model
    int          cnt;
    bit          busy;
    logic [7:0]  cz;
    logic [15:0] cx;
    cnt = 0; busy = 0; cz = '0; cx = '0;
    hl_done = 1'b0; hl_z = '0; hl_x = '0;
    forever begin
      @(posedge Clk);
      #1;
      if (Rst) begin
        busy    = 0;
        hl_done = 1'b0;
      end else if (hl_start) begin
        busy = 1;
        cnt  = core_lat;
        cz   = 8'(hl_a + hl_c);
        cx   = 16'(hl_b * 2);
        if (!core_sticky) hl_done = 1'b0;
      end else if (busy && !core_hang) begin
        cnt = cnt - 1;
        if (core_sticky && cnt == 1) hl_done = 1'b0;
        if (cnt == 0) begin
          hl_done = 1'b1;
          hl_z    = cz;
          hl_x    = cx;
          busy    = 0;
        end
      end
    end
  end

  // Randomised downstream back-pressure when enabled
  initial begin
    forever begin
      @(posedge Clk);
      #2;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Reference model and scoreboard: every accepted job owes exactly one
  // result in acceptance order; reset discards everything owed.
  always @(negedge Clk) begin
    if (Rst) begin
      exp_q.delete();
      exp_jobs = 0;
    end else begin
      if (out_valid && out_ready) begin
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          mis_cnt++;
          $display("FAIL pop_unexpected: got z=%0h x=%0h err=%0b, required no result", out_z, out_x, out_err);
        end else begin
          mon_e = exp_q.pop_front();
          if ({out_err, out_z, out_x} !== mon_e) begin
            mis_cnt++;
            $display("FAIL pop_data: got err=%0b z=%0h x=%0h, required err=%0b z=%0h x=%0h",
                     out_err, out_z, out_x, mon_e.err, mon_e.z, mon_e.x);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (!core_hang) begin
          exp_q.push_back('{err: 1'b0, z: 8'(in_a + in_c), x: 16'(in_b * 2)});
          exp_jobs++;
        end else begin
`ifdef HLSM_SEQ_WATCHDOG_EN
          exp_q.push_back('{err: 1'b1, z: 8'h0, x: 16'h0});
          exp_jobs++;
`endif
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  // ---- stimulus helpers (all return at posedge + 2) ----------------------
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic drive_job(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, output bit ok);
    bit acc;
    ok = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      acc = in_ready;
      step();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_c = 16'($urandom);
    cmp_cnt++;
    if (!ok) begin
      mis_cnt++;
      $display("FAIL accept_timeout: job a=%0h not accepted in 100 cycles, required acceptance", a);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    step();
    cmp_cnt++;
    if (!done) begin
      mis_cnt++;
      $display("FAIL drain_timeout: %0d results still owed after %0d cycles, required 0",
               exp_q.size(), budget);
    end
  endtask

  // ---- scenarios ---------------------------------------------------------
  task automatic test_reset();
    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0;
    repeat (3) step();
    @(negedge Clk);
    cmp_cnt++;
    if (in_ready !== 1'b0) begin mis_cnt++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    cmp_cnt++;
    if ({hl_start, hl_a, hl_b, hl_c} !== '0) begin
      mis_cnt++; $display("FAIL rst_core_if: got start=%b a=%0h b=%0h c=%0h required all 0", hl_start, hl_a, hl_b, hl_c);
    end
    cmp_cnt++;
    if ({out_valid, out_z, out_x, out_err} !== '0) begin
      mis_cnt++; $display("FAIL rst_out: got v=%b z=%0h x=%0h err=%b required all 0", out_valid, out_z, out_x, out_err);
    end
    cmp_cnt++;
    if (job_count !== 16'd0) begin mis_cnt++; $display("FAIL rst_job_count: got %0d required 0", job_count); end
    step();
    Rst = 1'b0;
    @(negedge Clk);
    cmp_cnt++;
    if (in_ready !== 1'b1) begin mis_cnt++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    step();
  endtask

  task automatic test_basic();
    bit ok;
    int starts, first;
    logic        rdy_first, err_first;
    logic [7:0]  z_first;
    logic [15:0] x_first;
    starts = 0; first = 0; rdy_first = 0; err_first = 1'bx; z_first = 'x; x_first = 'x;
    core_lat = 6; out_ready = 1'b0;
    drive_job(16'd3, 16'd4, 16'd5, ok);
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (hl_start) starts++;
      if (n == 1) begin
        cmp_cnt++;
        if ({hl_a, hl_b, hl_c} !== {16'd3, 16'd4, 16'd5}) begin
          mis_cnt++; $display("FAIL basic_operands: got %0h/%0h/%0h required 3/4/5", hl_a, hl_b, hl_c);
        end
      end
      if (n == 2) begin
        cmp_cnt++;
        if ({hl_a, hl_b, hl_c} !== {16'd3, 16'd4, 16'd5}) begin
          mis_cnt++; $display("FAIL basic_operand_hold: got %0h/%0h/%0h required 3/4/5", hl_a, hl_b, hl_c);
        end
      end
      if (out_valid && first == 0) begin
        first = n; rdy_first = in_ready; err_first = out_err; z_first = out_z; x_first = out_x;
      end
      step();
    end
    cmp_cnt++;
    if (starts != 1) begin mis_cnt++; $display("FAIL basic_start_width: got %0d cycles required 1", starts); end
    cmp_cnt++;
    if (first != 8) begin mis_cnt++; $display("FAIL basic_out_latency: got cycle %0d required 8", first); end
    cmp_cnt++;
    if ({err_first, z_first, x_first} !== {1'b0, 8'd8, 16'd8}) begin
      mis_cnt++; $display("FAIL basic_result: got err=%b z=%0h x=%0h required err=0 z=8 x=8", err_first, z_first, x_first);
    end
    cmp_cnt++;
    if (rdy_first !== 1'b1) begin mis_cnt++; $display("FAIL basic_ready_after_done: got %b required 1", rdy_first); end
    cmp_cnt++;
    if (job_count !== 16'd1) begin mis_cnt++; $display("FAIL basic_job_count: got %0d required 1", job_count); end
    out_ready = 1'b1;
    wait_drain(20);
    out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    bit ok, blocked;
    logic [15:0] a1, b1, c1, a3, b3, c3;
    a1 = 16'($urandom); b1 = 16'($urandom); c1 = 16'($urandom);
    a3 = 16'($urandom); b3 = 16'($urandom); c3 = 16'($urandom);
    out_ready = 1'b0; core_lat = 3;
    drive_job(a1, b1, c1, ok);
    repeat (8) step();
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
    repeat (8) step();
    in_valid = 1'b1; in_a = a3; in_b = b3; in_c = c3;
    blocked = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b1) blocked = 0;
      step();
    end
    cmp_cnt++;
    if (!blocked) begin mis_cnt++; $display("FAIL bp_hold: third job not held off with FIFO full, required in_ready=0 out_valid=1"); end
    @(negedge Clk);
    cmp_cnt++;
    if ({out_err, out_z, out_x} !== {1'b0, 8'(a1 + c1), 16'(b1 * 2)}) begin
      mis_cnt++; $display("FAIL bp_head: got z=%0h x=%0h required z=%0h x=%0h", out_z, out_x, 8'(a1 + c1), 16'(b1 * 2));
    end
    step();
    out_ready = 1'b1;
    drive_job(a3, b3, c3, ok);
    wait_drain(60);
    cmp_cnt++;
    if (job_count !== 16'(exp_jobs)) begin mis_cnt++; $display("FAIL bp_job_count: got %0d required %0d", job_count, exp_jobs); end
    out_ready = 1'b0;
  endtask

  task automatic test_sticky_done();
    bit ok;
    int first;
    first = 0;
    core_sticky = 1; core_lat = 6; out_ready = 1'b1;
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
    wait_drain(30);
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
    for (int n = 1; n <= 15; n++) begin
      @(negedge Clk);
      if (out_valid && first == 0) first = n;
      step();
    end
    cmp_cnt++;
    if (first != 8) begin mis_cnt++; $display("FAIL sticky_completion: got cycle %0d required 8", first); end
    wait_drain(20);
    core_sticky = 0; out_ready = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    bit ok;
    logic [15:0] a1, b1, c1, a2, b2, c2;
    a1 = 16'($urandom); b1 = 16'($urandom); c1 = 16'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom); c2 = 16'($urandom);
    out_ready = 1'b0; core_lat = 4;
    drive_job(a1, b1, c1, ok);
    repeat (10) step();
    drive_job(a2, b2, c2, ok);
    repeat (4) step();
    out_ready = 1'b1;
    @(negedge Clk);
    cmp_cnt++;
    if ({out_valid, out_z, out_x} !== {1'b1, 8'(a1 + c1), 16'(b1 * 2)}) begin
      mis_cnt++; $display("FAIL spp_first_head: got v=%b z=%0h x=%0h required v=1 z=%0h x=%0h", out_valid, out_z, out_x, 8'(a1 + c1), 16'(b1 * 2));
    end
    step();
    out_ready = 1'b0;
    @(negedge Clk);
    cmp_cnt++;
    if ({out_valid, out_z, out_x} !== {1'b1, 8'(a2 + c2), 16'(b2 * 2)}) begin
      mis_cnt++; $display("FAIL spp_second_head: got v=%b z=%0h x=%0h required v=1 z=%0h x=%0h", out_valid, out_z, out_x, 8'(a2 + c2), 16'(b2 * 2));
    end
    repeat (3) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge Clk);
    cmp_cnt++;
    if (out_valid !== 1'b0) begin mis_cnt++; $display("FAIL spp_count: got out_valid=%b after one pop, required 0", out_valid); end
    cmp_cnt++;
    if (job_count !== 16'(exp_jobs)) begin mis_cnt++; $display("FAIL spp_job_count: got %0d required %0d", job_count, exp_jobs); end
    step();
  endtask

  task automatic test_watchdog();
    bit ok;
`ifdef HLSM_SEQ_WATCHDOG_EN
    int first;
    logic        err_f, rdy_f;
    logic [7:0]  z_f;
    logic [15:0] x_f;
    first = 0; err_f = 1'bx; rdy_f = 1'bx; z_f = 'x; x_f = 'x;
    core_hang = 1; out_ready = 1'b0;
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
    for (int n = 1; n <= 30; n++) begin
      @(negedge Clk);
      if (out_valid && first == 0) begin
        first = n; err_f = out_err; z_f = out_z; x_f = out_x; rdy_f = in_ready;
      end
      step();
    end
    core_hang = 0;
    cmp_cnt++;
    if (first != 13) begin mis_cnt++; $display("FAIL wd_latency: got cycle %0d required 13", first); end
    cmp_cnt++;
    if ({err_f, z_f, x_f} !== {1'b1, 8'h0, 16'h0}) begin
      mis_cnt++; $display("FAIL wd_result: got err=%b z=%0h x=%0h required err=1 z=0 x=0", err_f, z_f, x_f);
    end
    cmp_cnt++;
    if (rdy_f !== 1'b1) begin mis_cnt++; $display("FAIL wd_idle: got in_ready=%b required 1", rdy_f); end
    out_ready = 1'b1;
    wait_drain(20);
    core_lat = 5;
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
    wait_drain(30);
    cmp_cnt++;
    if (job_count !== 16'(exp_jobs)) begin mis_cnt++; $display("FAIL wd_job_count: got %0d required %0d", job_count, exp_jobs); end
    out_ready = 1'b0;
`else
    bit quiet;
    core_hang = 1; out_ready = 1'b1;
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
    quiet = 1;
    for (int n = 0; n < 300; n++) begin
      @(negedge Clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b0) quiet = 0;
      step();
    end
    cmp_cnt++;
    if (!quiet) begin mis_cnt++; $display("FAIL nowd_wait_forever: hung job left WAIT, required WAIT indefinitely"); end
    core_hang = 0;
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    core_lat = 5;
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
    wait_drain(30);
    cmp_cnt++;
    if (job_count !== 16'(exp_jobs)) begin mis_cnt++; $display("FAIL nowd_job_count: got %0d required %0d", job_count, exp_jobs); end
    out_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_wait();
    bit ok, quiet;
    core_lat = 20; out_ready = 1'b0;
    drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
    repeat (5) step();
    Rst = 1'b1;
    @(negedge Clk);
    cmp_cnt++;
    if (in_ready !== 1'b0) begin mis_cnt++; $display("FAIL rmw_ready_in_reset: got %b required 0", in_ready); end
    step();
    Rst = 1'b0;
    @(negedge Clk);
    cmp_cnt++;
    if (in_ready !== 1'b1) begin mis_cnt++; $display("FAIL rmw_idle: got in_ready=%b required 1", in_ready); end
    cmp_cnt++;
    if ({hl_start, out_valid} !== 2'b00) begin mis_cnt++; $display("FAIL rmw_outputs: got start=%b out_valid=%b required 0/0", hl_start, out_valid); end
    cmp_cnt++;
    if (job_count !== 16'd0) begin mis_cnt++; $display("FAIL rmw_job_count: got %0d required 0", job_count); end
    cmp_cnt++;
    if ({hl_a, hl_b, hl_c} !== '0) begin mis_cnt++; $display("FAIL rmw_operands: got %0h/%0h/%0h required 0", hl_a, hl_b, hl_c); end
    step();
    out_ready = 1'b1;
    quiet = 1;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      if (out_valid !== 1'b0) quiet = 0;
      step();
    end
    cmp_cnt++;
    if (!quiet) begin mis_cnt++; $display("FAIL rmw_spurious: result appeared after reset, required none"); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bit ok;
    rand_ready = 1;
    for (int j = 0; j < 30; j++) begin
      core_lat = $urandom_range(1, 8);
      drive_job(16'($urandom), 16'($urandom), 16'($urandom), ok);
      repeat ($urandom_range(0, 3)) step();
    end
    rand_ready = 0;
    out_ready = 1'b1;
    wait_drain(200);
    cmp_cnt++;
    if (job_count !== 16'(exp_jobs)) begin mis_cnt++; $display("FAIL rand_job_count: got %0d required %0d", job_count, exp_jobs); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_sticky_done();
    test_simul_push_pop();
    test_watchdog();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
